rol_seq_32: RTL

- Multicycle rotate-left unit for the datapath ALU.
- Performs the opposite direction of the existing combinational rotate-right.
- Built as a 5-stage log-shifter iterated over one stage per clock, so it needs only a single 32-bit 2:1 rotate mux per stage.
- Start/busy/done handshake with the control unit; result is held stable in a register until the next accepted operation.

---
 rtl/rol_seq_32.sv | 74 +++++++
 1 files changed

// File: rtl/rol_seq_32.sv
// rol_seq_32: multicycle rotate-left, one log-shifter stage per clock
//   clock  - system clock, rising edge
//   reset  - synchronous active-high reset
//   start  - operation request, sampled only while idle
//   rIn    - operand to rotate
//   rotB   - rotate amount, only the low SH_W bits are used
//   rOut   - registered result, held until the next completion or reset
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse after rOut has been updated
module rol_seq_32 #(
    parameter int WIDTH = 32,
    parameter int SH_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] rIn,
    input  logic [WIDTH-1:0] rotB,
    output logic [WIDTH-1:0] rOut,
    output logic             busy,
    output logic             done
);
    localparam int ST_W = $clog2(SH_W);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SH_W-1:0]  amt_q, amt_d;
    logic [ST_W-1:0]  stage_q, stage_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rot [SH_W];
    logic [WIDTH-1:0] step;
    logic             idle, last;
    // fixed rotate-left by 2**i for each stage; the active stage picks one
    for (genvar i = 0; i < SH_W; i++) begin : g_rot
        assign rot[i] = {work_q[WIDTH-1-(2**i):0], work_q[WIDTH-1:WIDTH-(2**i)]};
    end
    always_comb begin
        idle    = state_q == IDLE;
        last    = stage_q == '0;
        step    = amt_q[stage_q] ? rot[stage_q] : work_q;
        state_d = idle ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
        work_d  = idle ? (start ? rIn : work_q) : step;
        amt_d   = (idle && start) ? rotB[SH_W-1:0] : amt_q;
        stage_d = idle ? (start ? ST_W'(SH_W-1) : stage_q) : (last ? '0 : stage_q - 1'b1);
        rout_d  = (!idle && last) ? step : rout_q;
        busy_d  = idle ? start : !last;
        done_d  = !idle && last;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            amt_q   <= '0;
            stage_q <= '0;
            rout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            stage_q <= stage_d;
            rout_q  <= rout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign rOut = rout_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
